// File: rtl/inst_mem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
package inst_mem_pkg;

    localparam int unsigned DEF_INST_ADDR_WIDTH = 16;
    localparam int unsigned DEF_INST_DATA_WIDTH = 16;
    localparam int unsigned DEF_INST_MEM_SIZE   = 4096;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_e;

    // Compare in 32 bits so the last-word bound never wraps for a 16-bit address.
    function automatic logic in_range(input logic [31:0] addr, input int unsigned mem_size);
        return addr <= (mem_size - 32'd2);
    endfunction

endpackage

// File: rtl/inst_arb2.sv
// Two-requester arbiter: fixed load-over-fetch priority, or round-robin when
// INST_ARB_RR_EN is defined.
module inst_arb2 (
`ifdef INST_ARB_RR_EN
    input  logic clk_i,
    input  logic rst_ni,
`endif
    input  logic en_i,
    input  logic req_load_i,
    input  logic req_fetch_i,
    output logic gnt_load_o,
    output logic gnt_fetch_o
);

`ifdef INST_ARB_RR_EN
    logic prefer_load_q, prefer_load_d;

    always_comb begin
        gnt_load_o    = en_i & req_load_i & (prefer_load_q | ~req_fetch_i);
        gnt_fetch_o   = en_i & req_fetch_i & ~(req_load_i & prefer_load_q);
        prefer_load_d = prefer_load_q;
        if (gnt_load_o)
            prefer_load_d = 1'b0;
        else if (gnt_fetch_o)
            prefer_load_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            prefer_load_q <= 1'b1;
        else
            prefer_load_q <= prefer_load_d;
    end
`else
    always_comb begin
        gnt_load_o  = en_i & req_load_i;
        gnt_fetch_o = en_i & req_fetch_i & ~req_load_i;
    end
`endif

endmodule

// File: rtl/inst_mem_arbiter.sv
// Shares one synchronous instruction-memory port between fetch reads and loader
// writes. Optional macro INST_ARB_RR_EN selects round-robin arbitration.
module inst_mem_arbiter
    import inst_mem_pkg::*;
#(
    parameter int unsigned INST_ADDR_WIDTH = DEF_INST_ADDR_WIDTH,
    parameter int unsigned INST_DATA_WIDTH = DEF_INST_DATA_WIDTH,
    parameter int unsigned INST_MEM_SIZE   = DEF_INST_MEM_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_req,
    input  logic [INST_ADDR_WIDTH-1:0] fetch_addr,
    output logic                       fetch_gnt,
    output logic                       fetch_valid,
    output logic [INST_DATA_WIDTH-1:0] fetch_data,
    output logic                       fetch_exc,
    input  logic                       load_req,
    input  logic [INST_ADDR_WIDTH-1:0] load_addr,
    input  logic [INST_DATA_WIDTH-1:0] load_data,
    output logic                       load_gnt,
    output logic                       load_done,
    output logic                       load_exc,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [INST_ADDR_WIDTH-1:0] mem_addr,
    output logic [INST_DATA_WIDTH-1:0] mem_wdata,
    input  logic [INST_DATA_WIDTH-1:0] mem_rdata
);

    state_e                     state_q;
    logic                       fetch_valid_q, fetch_exc_q;
    logic                       load_done_q, load_exc_q;
    logic [INST_DATA_WIDTH-1:0] fetch_data_q;

    logic                       arb_en, gnt_load, gnt_fetch;
    logic [INST_ADDR_WIDTH-1:0] sel_addr;
    logic                       addr_ok;

    assign arb_en = rst & (state_q == IDLE);

    inst_arb2 u_arb (
`ifdef INST_ARB_RR_EN
        .clk_i       (clk),
        .rst_ni      (rst),
`endif
        .en_i        (arb_en),
        .req_load_i  (load_req),
        .req_fetch_i (fetch_req),
        .gnt_load_o  (gnt_load),
        .gnt_fetch_o (gnt_fetch)
    );

    always_comb begin
        sel_addr  = gnt_load ? load_addr : fetch_addr;
        addr_ok   = in_range(32'(sel_addr), INST_MEM_SIZE);
        mem_en    = (gnt_load | gnt_fetch) & addr_ok;
        mem_we    = gnt_load & addr_ok;
        mem_addr  = mem_en ? sel_addr : '0;
        mem_wdata = mem_we ? load_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            fetch_valid_q <= 1'b0;
            fetch_exc_q   <= 1'b0;
            load_done_q   <= 1'b0;
            load_exc_q    <= 1'b0;
            fetch_data_q  <= '0;
        end else begin
            fetch_valid_q <= 1'b0;
            fetch_exc_q   <= 1'b0;
            load_done_q   <= 1'b0;
            load_exc_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_load) begin
                        state_q     <= RESP;
                        load_done_q <= 1'b1;
                        load_exc_q  <= ~addr_ok;
                    end else if (gnt_fetch) begin
                        if (addr_ok) begin
                            state_q <= RD_WAIT;
                        end else begin
                            // Rejected fetch skips the memory and answers one cycle early.
                            state_q       <= RESP;
                            fetch_valid_q <= 1'b1;
                            fetch_exc_q   <= 1'b1;
                            fetch_data_q  <= '0;
                        end
                    end
                end
                RD_WAIT: begin
                    state_q       <= RESP;
                    fetch_data_q  <= mem_rdata;
                    fetch_valid_q <= 1'b1;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fetch_gnt   = gnt_fetch;
    assign load_gnt    = gnt_load;
    assign fetch_valid = fetch_valid_q;
    assign fetch_exc   = fetch_exc_q;
    assign fetch_data  = fetch_data_q;
    assign load_done   = load_done_q;
    assign load_exc    = load_exc_q;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Directed self-checking bench for inst_mem_arbiter with a byte-array memory model.
module tb_inst_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, load_req;
    logic [15:0] fetch_addr, load_addr, load_data;
    logic        fetch_gnt, fetch_valid, fetch_exc;
    logic [15:0] fetch_data;
    logic        load_gnt, load_done, load_exc;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0]  mem [0:4095];

    always #5 clk = ~clk;

    inst_mem_arbiter #(
        .INST_ADDR_WIDTH (16),
        .INST_DATA_WIDTH (16),
        .INST_MEM_SIZE   (4096)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_exc   (fetch_exc),
        .load_req    (load_req),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_gnt    (load_gnt),
        .load_done   (load_done),
        .load_exc    (load_exc),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Synchronous little-endian memory: read data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[11:0]]         <= mem_wdata[7:0];
                mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
            end else begin
                mem_rdata <= {mem[mem_addr[11:0] + 12'd1], mem[mem_addr[11:0]]};
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [15:0] addr, input logic [15:0] exp_data, input logic exp_exc);
        tick();
        fetch_req  = 1'b1;
        fetch_addr = addr;
        #1;
        check_eq("fetch_gnt", 32'(fetch_gnt), 32'd1);
        check_eq("fetch_mem_en", 32'(mem_en), 32'(!exp_exc));
        check_eq("fetch_mem_we", 32'(mem_we), 32'd0);
        check_eq("fetch_mem_addr", 32'(mem_addr), exp_exc ? 32'd0 : 32'(addr));
        tick();
        fetch_req = 1'b0;
        if (exp_exc) begin
            check_eq("fetch_exc_valid", 32'(fetch_valid), 32'd1);
            check_eq("fetch_exc_flag", 32'(fetch_exc), 32'd1);
            check_eq("fetch_exc_data", 32'(fetch_data), 32'd0);
        end else begin
            check_eq("fetch_valid_n1", 32'(fetch_valid), 32'd0);
            tick();
            check_eq("fetch_valid_n2", 32'(fetch_valid), 32'd1);
            check_eq("fetch_exc_n2", 32'(fetch_exc), 32'd0);
            check_eq("fetch_data", 32'(fetch_data), 32'(exp_data));
        end
        tick();
        check_eq("fetch_valid_after", 32'(fetch_valid), 32'd0);
        check_eq("fetch_data_hold", 32'(fetch_data), 32'(exp_data));
    endtask

    task automatic do_load(input logic [15:0] addr, input logic [15:0] data, input logic exp_exc);
        tick();
        load_req  = 1'b1;
        load_addr = addr;
        load_data = data;
        #1;
        check_eq("load_gnt", 32'(load_gnt), 32'd1);
        check_eq("load_mem_en", 32'(mem_en), 32'(!exp_exc));
        check_eq("load_mem_we", 32'(mem_we), 32'(!exp_exc));
        check_eq("load_mem_wdata", 32'(mem_wdata), exp_exc ? 32'd0 : 32'(data));
        tick();
        load_req = 1'b0;
        check_eq("load_done", 32'(load_done), 32'd1);
        check_eq("load_exc", 32'(load_exc), 32'(exp_exc));
        tick();
        check_eq("load_done_after", 32'(load_done), 32'd0);
    endtask

    initial begin
        logic [5:0] exp_seq;
        int unsigned grants;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'hEF;
        mem[16'h0011] = 8'hBE;
        mem_rdata  = '0;
        rst        = 1'b0;
        fetch_req  = 1'b1;
        load_req   = 1'b1;
        fetch_addr = 16'h0010;
        load_addr  = 16'h0020;
        load_data  = 16'h1111;

        tick();
        tick();
        check_eq("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
        check_eq("rst_load_gnt", 32'(load_gnt), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_bus", {mem_addr, mem_wdata}, 32'd0);
        check_eq("rst_resp", {28'd0, fetch_valid, fetch_exc, load_done, load_exc}, 32'd0);
        check_eq("rst_fetch_data", 32'(fetch_data), 32'd0);
        fetch_req = 1'b0;
        load_req  = 1'b0;
        rst       = 1'b1;

        do_fetch(16'h0010, 16'hBEEF, 1'b0);
        do_load(16'h0020, 16'h1234, 1'b0);
        do_fetch(16'h0020, 16'h1234, 1'b0);
        do_fetch(16'h0FFF, 16'h0000, 1'b1);
        do_fetch(16'hFFFF, 16'h0000, 1'b1);
        do_load(16'h0FFE, 16'hA55A, 1'b0);
        do_load(16'hFFFF, 16'h5555, 1'b1);
        do_fetch(16'h0FFE, 16'hA55A, 1'b0);

        // Reset landing in RD_WAIT must drop the pending response.
        tick();
        fetch_req  = 1'b1;
        fetch_addr = 16'h0010;
        #1;
        check_eq("rdw_gnt", 32'(fetch_gnt), 32'd1);
        tick();
        fetch_req = 1'b0;
        rst       = 1'b0;
        tick();
        rst       = 1'b1;
        fetch_req = 1'b1;
        #1;
        check_eq("rdw_no_valid", 32'(fetch_valid), 32'd0);
        check_eq("rdw_data_cleared", 32'(fetch_data), 32'd0);
        check_eq("rdw_regrant", 32'(fetch_gnt), 32'd1);
        tick();
        fetch_req = 1'b0;
        check_eq("rdw_valid_n1", 32'(fetch_valid), 32'd0);
        tick();
        check_eq("rdw_valid_n2", 32'(fetch_valid), 32'd1);
        check_eq("rdw_data", 32'(fetch_data), 32'h0000BEEF);

        // Contention from a fresh reset so the round-robin pointer favours load.
        tick();
        rst = 1'b0;
        tick();
        rst        = 1'b1;
        fetch_req  = 1'b1;
        load_req   = 1'b1;
        fetch_addr = 16'h0010;
        load_addr  = 16'h0040;
        load_data  = 16'h7777;
`ifdef INST_ARB_RR_EN
        exp_seq = 6'b101010;
`else
        exp_seq = 6'b111111;
`endif
        grants = 0;
        for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
            #1;
            if (fetch_gnt && load_gnt)
                check_eq("arb_two_gnts", 32'd2, 32'd1);
            if (fetch_gnt || load_gnt) begin
                check_eq($sformatf("arb_grant%0d_is_load", grants), 32'(load_gnt),
                         32'(exp_seq[5 - grants]));
                grants++;
            end
            tick();
        end
        check_eq("arb_grant_count", grants, 32'd6);
        fetch_req = 1'b0;
        load_req  = 1'b0;
        tick();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_mem_arbiter.md
# inst_mem_arbiter

Two-port arbiter and sequencer in front of the byte-organised instruction memory. It shares the single memory port between the CPU fetch stage, which reads 16-bit words, and the program loader, which writes 16-bit words. It range-checks every access, drives the memory's synchronous port, and returns read data or exceptions to the requester with a fixed latency.

## Interface
- INST_ADDR_WIDTH, 16, byte address width
- INST_DATA_WIDTH, 16, word width (two bytes, little-endian: low byte at addr)
- INST_MEM_SIZE, 4096, memory size in bytes
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- fetch_req  in  1  fetch request, held until fetch_gnt
- fetch_addr  in  INST_ADDR_WIDTH  fetch byte address, sampled when fetch_gnt=1
- fetch_gnt  out  1  fetch accepted this cycle (combinational)
- fetch_valid  out  1  one-cycle pulse: fetch_data/fetch_exc valid
- fetch_data  out  INST_DATA_WIDTH  fetched word
- fetch_exc  out  1  fetch address out of range (qualified by fetch_valid)
- load_req  in  1  write request, held until load_gnt
- load_addr  in  INST_ADDR_WIDTH  write byte address
- load_data  in  INST_DATA_WIDTH  write word
- load_gnt  out  1  write accepted this cycle (combinational)
- load_done  out  1  one-cycle pulse: write complete or rejected
- load_exc  out  1  write address out of range (qualified by load_done)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  INST_ADDR_WIDTH  memory byte address
- mem_wdata  out  INST_DATA_WIDTH  memory write word
- mem_rdata  in  INST_DATA_WIDTH  memory read word, valid the cycle after mem_en

## Operation
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE: arbitrate among asserted requests.
  - Winner gets gnt in the same cycle.
  - Address in range (addr <= INST_MEM_SIZE-2): drive mem_en=1, mem_addr=addr, mem_we=1 and mem_wdata for a load.
  - Grant a fetch -> RD_WAIT. Grant a load -> RESP.
- Out-of-range access:
  - Still granted, but no memory access (mem_en=0).
  - Go to RESP with the exc flag set.
  - An out-of-range fetch returns fetch_data=0.
- RD_WAIT: register mem_rdata into fetch_data -> RESP.
- RESP: pulse fetch_valid or load_done (plus exc) -> IDLE.
- Grants only in IDLE; at most one gnt per cycle.
- Requester must hold req, addr and data stable until gnt.
- Arbitration without INST_ARB_RR_EN: load has fixed priority over fetch.
- mem_en, mem_we, mem_addr and mem_wdata are 0 whenever no access is granted.
- Address arithmetic is unsigned INST_ADDR_WIDTH. The range comparison must not wrap at 0xFFFF: addr=0xFFFF is out of range.
- Reset values (rst=0 at a clk edge):
  - State IDLE.
  - Outputs all 0: fetch_gnt/valid/data/exc, load_gnt/done/exc, mem_*.
  - RR pointer selects load.
- Reset mid-transaction discards the transaction: no valid/done pulse afterwards.
- gnt is gated with rst=1.

## Timing
- Fetch: gnt/mem_en at cycle N, mem_rdata at N+1, fetch_valid and fetch_data at N+2. Next grant earliest N+3.
- Load: gnt/mem_en/mem_we at N, load_done at N+1. Next grant earliest N+2.
- Exception: gnt at N, pulse at N+1 for both fetch and load.
- fetch_data holds its value until the next fetch response. fetch_exc and load_exc are 0 outside their pulses.

## Configuration
- INST_ARB_RR_EN defined: two-way round-robin arbitration.
  - On simultaneous requests, grant the requester not granted last.
  - The pointer updates on every grant.
- INST_ARB_RR_EN undefined: fixed priority, load over fetch. No pointer register.

## Structure
- Package inst_mem_pkg holds:
  - state enum (IDLE, RD_WAIT, RESP)
  - default INST_MEM_SIZE / INST_ADDR_WIDTH / INST_DATA_WIDTH constants
  - in_range(addr) function
- Sub-module inst_arb2: two-requester arbiter, with the round-robin pointer under INST_ARB_RR_EN.

## Test plan
- Reset: rst=0 for 2 cycles while both req=1 -> all outputs 0, no gnt.
- Fetch addr 0x0010, memory model returns 0xBEEF -> fetch_gnt at N, mem_en/mem_addr=0x0010 at N, fetch_valid=1 with fetch_data=0xBEEF at N+2.
- Load addr 0x0020, data 0x1234, then fetch 0x0020 -> mem_we=1 at grant, load_done at N+1, fetch returns 0x1234.
- Fetch addr 0x0FFF and 0xFFFF -> no mem_en, fetch_valid+fetch_exc=1 at N+1, fetch_data=0. Load addr 0x0FFE -> no exc.
- Both req=1 held for 6 grants -> without INST_ARB_RR_EN all loads first; with INST_ARB_RR_EN grants alternate load, fetch, load, ...
- rst=0 in the RD_WAIT cycle of a fetch -> no fetch_valid pulse afterwards, state IDLE, a new request is granted in the first cycle after rst=1.
